// File: rtl/net_frame_echo.sv
// rtl/net_frame_echo.sv - store-and-forward Ethernet frame echo with MAC address swap
// Buffers one RX frame in a BRAM, then replays it on TX; runts and oversize frames are dropped.
module net_frame_echo #(
  parameter int BUF_DEPTH = 2048,
  parameter int MIN_LEN   = 14
) (
  input  logic        axis_aclk,
  input  logic        axis_rst,
  input  logic [7:0]  S_AXIS_tdata,
  input  logic        S_AXIS_tvalid,
  input  logic        S_AXIS_tlast,
  output logic        S_AXIS_tready,
  output logic [7:0]  M_AXIS_tdata,
  output logic        M_AXIS_tvalid,
  output logic        M_AXIS_tlast,
  input  logic        M_AXIS_tready,
  input  logic        swap_en,
  output logic [15:0] frames_echoed,
  output logic [15:0] frames_dropped
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0]   MIN_L  = (AW+1)'(MIN_LEN);
  localparam logic [AW:0]   FULL   = (AW+1)'(BUF_DEPTH - 1);
  localparam logic [AW:0]   SIX    = (AW+1)'(6);
  localparam logic [AW:0]   TWELVE = (AW+1)'(12);
  localparam logic [AW-1:0] OFS    = AW'(6);

  typedef enum logic [1:0] {RX, DROP, TX} state_t;
  state_t state, state_nxt;

  logic [7:0]    mem [BUF_DEPTH];
  logic [AW:0]   wr_cnt, len_rx, len_q, rd_idx;
  logic [AW-1:0] rd_addr;
  logic [7:0]    ram_q, skid_data;
  logic          ram_last, skid_last, q_valid, skid_valid;
  logic          swap_q, alive;
  logic          rx_hs, wr_en, tx_hs, tx_done, rd_en, accept_evt, drop_evt;

  always_comb begin
    state_nxt     = state;
    accept_evt    = 1'b0;
    drop_evt      = 1'b0;
    S_AXIS_tready = alive && (state != TX);
    rx_hs         = S_AXIS_tvalid && S_AXIS_tready;
    wr_en         = rx_hs && (state == RX);
    len_rx        = wr_cnt + 1'b1;
    M_AXIS_tvalid = skid_valid || q_valid;
    M_AXIS_tdata  = skid_valid ? skid_data : (q_valid ? ram_q : 8'h00);
    M_AXIS_tlast  = skid_valid ? skid_last : (q_valid && ram_last);
    tx_hs         = M_AXIS_tvalid && M_AXIS_tready;
    tx_done       = tx_hs && M_AXIS_tlast;
    // Reads are gated only by skid occupancy so tready never reaches the RAM enable.
    rd_en         = (state == TX) && (rd_idx != len_q) && !skid_valid;
    case (state)
      RX: begin
        if (rx_hs && S_AXIS_tlast) begin
          if (len_rx < MIN_L) begin
            drop_evt = 1'b1;
          end else begin
            accept_evt = 1'b1;
            state_nxt  = TX;
          end
        end else if (rx_hs && (wr_cnt == FULL)) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (rx_hs && S_AXIS_tlast) begin
          drop_evt  = 1'b1;
          state_nxt = RX;
        end
      end
      TX: begin
        if (tx_done) state_nxt = RX;
      end
      default: state_nxt = RX;
    endcase
  end

  always_comb begin
    rd_addr = rd_idx[AW-1:0];
    if (swap_q && (rd_idx < SIX))
      rd_addr = rd_idx[AW-1:0] + OFS;
    else if (swap_q && (rd_idx < TWELVE))
      rd_addr = rd_idx[AW-1:0] - OFS;
  end

  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) state <= RX;
    else          state <= state_nxt;
  end

  always_ff @(posedge axis_aclk) begin
    if (wr_en) mem[wr_cnt[AW-1:0]] <= S_AXIS_tdata;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      alive          <= 1'b0;
      wr_cnt         <= '0;
      len_q          <= '0;
      swap_q         <= 1'b0;
      rd_idx         <= '0;
      q_valid        <= 1'b0;
      ram_last       <= 1'b0;
      skid_valid     <= 1'b0;
      skid_data      <= 8'h00;
      skid_last      <= 1'b0;
      frames_echoed  <= 16'h0000;
      frames_dropped <= 16'h0000;
    end else begin
      alive <= 1'b1;
      if (tx_done || drop_evt)                       wr_cnt <= '0;
      else if (wr_en && !(S_AXIS_tlast && accept_evt)) wr_cnt <= wr_cnt + 1'b1;
      if (accept_evt) begin
        len_q  <= len_rx;
        swap_q <= swap_en;
      end
      if (tx_done)    rd_idx <= '0;
      else if (rd_en) rd_idx <= rd_idx + 1'b1;
      if (rd_en) begin
        q_valid  <= 1'b1;
        ram_last <= (rd_idx == len_q - 1'b1);
      end else if (tx_hs && !skid_valid) begin
        q_valid <= 1'b0;
      end
      // A stalled ram_q about to be overwritten by the next read parks in the skid.
      if (skid_valid && M_AXIS_tready) begin
        skid_valid <= 1'b0;
      end else if (!skid_valid && q_valid && !M_AXIS_tready && rd_en) begin
        skid_valid <= 1'b1;
        skid_data  <= ram_q;
        skid_last  <= ram_last;
      end
      if (tx_done)  frames_echoed  <= frames_echoed + 16'd1;
      if (drop_evt) frames_dropped <= frames_dropped + 16'd1;
    end
  end

endmodule

// File: tb/tb_net_frame_echo.sv
// tb/tb_net_frame_echo.sv - directed bench for net_frame_echo with BUF_DEPTH=64
module tb_net_frame_echo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic        swap_en = 1'b1;
  logic [15:0] echoed, dropped;

  int total = 0;
  int bad = 0;
  logic [7:0] fr    [0:127];
  logic [7:0] exp_b [0:127];
  logic [7:0] got   [0:127];

  always #4 clk = ~clk;

  net_frame_echo #(.BUF_DEPTH(64), .MIN_LEN(14)) dut (
    .axis_aclk(clk), .axis_rst(rst),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tlast(s_tlast), .S_AXIS_tready(s_tready),
    .M_AXIS_tdata(m_tdata), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tlast(m_tlast), .M_AXIS_tready(m_tready),
    .swap_en(swap_en), .frames_echoed(echoed), .frames_dropped(dropped)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pat(input int s, input int i);
    int v;
    v = (s == 0) ? i : (s * 37 + i * 5);
    return v[7:0];
  endfunction

  task automatic build(input int n, input int seed, input bit sw);
    for (int i = 0; i < n; i++) fr[i] = pat(seed, i);
    for (int i = 0; i < n; i++)
      exp_b[i] = (sw && i < 6) ? fr[i+6] : ((sw && i < 12) ? fr[i-6] : fr[i]);
  endtask

  // Called at a negedge; returns at the negedge after the tlast handshake.
  task automatic send(input int n, input bit hold, input logic [7:0] next0);
    int w;
    for (int i = 0; i < n; i++) begin
      s_tdata  = fr[i];
      s_tvalid = 1'b1;
      s_tlast  = (i == n - 1);
      w = 0;
      while (!s_tready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) check("rx_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
    end
    s_tlast = 1'b0;
    if (hold) s_tdata = next0;
    else s_tvalid = 1'b0;
  endtask

  task automatic recv(input int n, input int stop_after, input bit stall);
    int idx, cyc, first, err_rdy, err_stable;
    logic [7:0] pd;
    logic pv;
    idx = 0; cyc = 0; first = -1; err_rdy = 0; err_stable = 0; pv = 1'b0; pd = 8'h00;
    while (idx < stop_after && cyc < 4 * n + 50) begin
      if (pv && (m_tdata !== pd || m_tvalid !== 1'b1)) err_stable++;
      if (s_tready !== 1'b0) err_rdy++;
      m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_tvalid && m_tready) begin
        if (first < 0) first = cyc;
        got[idx] = m_tdata;
        check("tx_data", {24'd0, m_tdata}, {24'd0, exp_b[idx]});
        check("tx_last", {31'd0, m_tlast}, {31'd0, (idx == n - 1)});
        idx++;
      end
      pv = m_tvalid && !m_tready;
      pd = m_tdata;
      @(negedge clk);
      cyc++;
    end
    check("tx_count", idx, stop_after);
    check("rx_ready_low_in_tx", err_rdy, 0);
    if (stall) check("tx_stable_under_stall", err_stable, 0);
    if (!stall && stop_after == n) begin
      check("tx_latency", first, 1);
      check("tx_gapless", cyc - first, n);
    end
    if (idx == n) begin
      check("turnaround_ready", {31'd0, s_tready}, 32'd1);
      check("tx_idle_after", {31'd0, m_tvalid}, 32'd0);
    end
    m_tready = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_s_tready", {31'd0, s_tready}, 32'd0);
    check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_m_tdata", {24'd0, m_tdata}, 32'd0);
    check("rst_echoed", {16'd0, echoed}, 32'd0);
    check("rst_dropped", {16'd0, dropped}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, s_tready}, 32'd1);

    // 64-byte frame, swapped, no stalls
    swap_en = 1'b1;
    build(64, 0, 1'b1);
    send(64, 1'b0, 8'h00);
    check("latency_t1", {31'd0, m_tvalid}, 32'd0);
    recv(64, 64, 1'b0);
    check("t1_b0", {24'd0, got[0]}, 32'h06);
    check("t1_b5", {24'd0, got[5]}, 32'h0B);
    check("t1_b6", {24'd0, got[6]}, 32'h00);
    check("t1_b11", {24'd0, got[11]}, 32'h05);
    check("t1_b12", {24'd0, got[12]}, 32'h0C);
    check("t1_b63", {24'd0, got[63]}, 32'h3F);
    check("t1_echoed", {16'd0, echoed}, 32'd1);

    // Same frame unswapped with random stalls; swap_en toggled mid-TX must not matter
    swap_en = 1'b0;
    build(64, 0, 1'b0);
    send(64, 1'b0, 8'h00);
    swap_en = 1'b1;
    recv(64, 64, 1'b1);
    check("t2_b0", {24'd0, got[0]}, 32'h00);
    check("t2_b6", {24'd0, got[6]}, 32'h06);
    check("t2_echoed", {16'd0, echoed}, 32'd2);

    // 13-byte runt dropped, then a 14-byte frame echoed
    build(13, 3, 1'b1);
    send(13, 1'b0, 8'h00);
    check("runt_dropped", {16'd0, dropped}, 32'd1);
    repeat (3) begin
      check("runt_ready", {31'd0, s_tready}, 32'd1);
      check("runt_no_tx", {31'd0, m_tvalid}, 32'd0);
      @(negedge clk);
    end
    build(14, 4, 1'b1);
    send(14, 1'b0, 8'h00);
    recv(14, 14, 1'b0);
    check("t3_echoed", {16'd0, echoed}, 32'd3);

    // 65-byte oversize frame dropped, then 20-byte frame echoed
    build(65, 5, 1'b1);
    send(65, 1'b0, 8'h00);
    check("over_dropped", {16'd0, dropped}, 32'd2);
    repeat (3) begin
      check("over_no_tx", {31'd0, m_tvalid}, 32'd0);
      @(negedge clk);
    end
    build(20, 6, 1'b1);
    send(20, 1'b0, 8'h00);
    recv(20, 20, 1'b0);
    check("t4_echoed", {16'd0, echoed}, 32'd4);

    // Three back-to-back 60-byte frames with RX tvalid held high
    for (int k = 0; k < 3; k++) begin
      build(60, 10 + k, 1'b1);
      send(60, (k < 2), pat(11 + k, 0));
      recv(60, 60, 1'b0);
    end
    check("b2b_echoed", {16'd0, echoed}, 32'd7);

    // Reset in the middle of TX, then a clean echo
    build(40, 20, 1'b1);
    send(40, 1'b0, 8'h00);
    recv(40, 30, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("mid_rst_echoed", {16'd0, echoed}, 32'd0);
    check("mid_rst_dropped", {16'd0, dropped}, 32'd0);
    check("mid_rst_ready", {31'd0, s_tready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rerst_ready", {31'd0, s_tready}, 32'd1);
    build(20, 21, 1'b1);
    send(20, 1'b0, 8'h00);
    recv(20, 20, 1'b0);
    check("t6_echoed", {16'd0, echoed}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
